// File: rtl/l524_rom_icb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l524_rom_icb_ctrl : ICB slave front end for the boot mask ROM            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module l524_rom_icb_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [31:0]           icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [31:0]           icb_cmd_wdata,
  input  logic [3:0]            icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic                  icb_rsp_err,
  output logic [DATA_WIDTH-1:0] icb_rsp_rdata,
  output logic [ADDR_WIDTH-3:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  logic [1:0]            r_count;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_err;
  logic [DATA_WIDTH-1:0] r_rdata [2];

  logic w_hit;
  logic w_err;
  logic w_push;
  logic w_pop;
  logic w_unused_ok;

  // The ROM has no write port; write data and mask are deliberately dropped.
  assign w_unused_ok = ^{icb_cmd_wdata, icb_cmd_wmask};

  assign rom_addr = icb_cmd_addr[ADDR_WIDTH-1:2];
  assign w_hit    = (icb_cmd_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign w_err    = ~icb_cmd_read | ~w_hit | (icb_cmd_addr[1:0] != 2'b00);

  assign icb_cmd_ready = (r_count != 2'd2) | icb_rsp_ready;
  assign icb_rsp_valid = (r_count != 2'd0);
  assign icb_rsp_err   = icb_rsp_valid ? r_err[r_rptr]   : 1'b0;
  assign icb_rsp_rdata = icb_rsp_valid ? r_rdata[r_rptr] : '0;

  assign w_push = icb_cmd_valid & icb_cmd_ready;
  assign w_pop  = icb_rsp_valid & icb_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_err      <= 2'b00;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      if (w_push) begin
        r_err[r_wptr]   <= w_err;
        r_rdata[r_wptr] <= w_err ? '0 : rom_dout;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/l524_rom_icb_ctrl.md
Name: l524_rom_icb_ctrl

Overview:
ICB slave front end for the on-chip boot mask ROM.
- Accepts single-beat ICB commands from the core's fetch/LSU bus and drives the ROM word address.
- The ROM read is combinational; the controller registers the ROM data into a 2-entry response buffer.
- Returns responses in order with valid/ready back-pressure.
- Writes, misaligned accesses and out-of-window addresses complete with an error response instead of touching the ROM.

Parameters:
ADDR_WIDTH, 12, byte-address width of the ROM window (window = 2^ADDR_WIDTH bytes).
DATA_WIDTH, 32, ROM word / ICB data width; only 32 is supported.
BASE_ADDR, 32'h0000_1000, ICB base address of the ROM window; must be 2^ADDR_WIDTH aligned.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_addr  in  32  byte address
icb_cmd_read  in  1  1 = read, 0 = write
icb_cmd_wdata  in  32  write data (ignored)
icb_cmd_wmask  in  4  write byte mask (ignored)
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_err  out  1  response error flag
icb_rsp_rdata  out  32  response read data
rom_addr  out  ADDR_WIDTH-2  ROM word address, to ROM rom_addr
rom_dout  in  DATA_WIDTH  ROM read data, from ROM rom_dout, combinational

Behaviour:
Reset and ROM address
- Asynchronous: rst_n low immediately clears buffer entries, pointers and count.
- Reset state: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, icb_cmd_ready=1.
- rom_addr = icb_cmd_addr[ADDR_WIDTH-1:2], combinational and unregistered. It may toggle freely when no command is accepted.

Command handshake and error decode
- A command is accepted on a rising edge with icb_cmd_valid & icb_cmd_ready.
- icb_cmd_ready = (count<2) | (count==2 & icb_rsp_ready). Pop and push may occur in the same cycle when the buffer is full.
- hit = (icb_cmd_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]).
- err = ~icb_cmd_read | ~hit | (icb_cmd_addr[1:0]!=0).

Response buffer (2 entries, each {err, rdata})
- On accept, push {err, err ? 0 : rom_dout}. rom_dout is sampled in the same cycle as the accept.
- Head entry drives icb_rsp_*. icb_rsp_valid = (count!=0), registered-based, no combinational path from icb_cmd_valid.
- Pop on icb_rsp_valid & icb_rsp_ready.
- When empty, icb_rsp_err and icb_rsp_rdata read 0.
- Latency: response valid exactly 1 cycle after accept when the buffer is empty at accept.
- Throughput: 1 command/cycle sustained while icb_rsp_ready=1.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, pointers both advance.
  - Count never exceeds 2 and never underflows.
- Responses are strictly in command order. Error responses are ordered with normal ones.
- Write-pointer and read-pointer wrap modulo 2.
- Write data and write mask never reach the ROM. There is no write path.

Test Plan:
1. Reset: hold rst_n=0 with cmd_valid=1 -> cmd_ready=1, rsp_valid=0, rdata=0, no push. Release -> first accepted read to 0x1000 gives rsp_valid next cycle, err=0, rdata=ROM[0] (boot image word 0x7ffff297).
2. Back-to-back: reads 0x1000, 0x1004, 0x1008 on consecutive cycles with rsp_ready=1 -> responses on the 3 following cycles, rdata 0x7ffff297, 0x00028067, 0x00000000, cmd_ready stays 1.
3. Back-pressure: rsp_ready=0, issue 3 reads -> first 2 accepted, cmd_ready=0 on the 3rd. Raise rsp_ready -> 3rd accepted in the same cycle as the pop, order preserved.
4. Errors:
   - write to 0x1000 -> err=1, rdata=0
   - read 0x2000 -> err=1
   - read 0x1002 -> err=1
   - ROM contents unchanged: a subsequent read of 0x1000 returns 0x7ffff297.
5. Mid-operation reset: buffer holding 2 entries, pulse rst_n low asynchronously between edges -> rsp_valid drops immediately, count=0, old data never presented after release.
6. Random valid/ready toggling over 10k cycles against a reference queue model -> no lost, duplicated or reordered responses, count within [0,2].
